// File: rtl/key_search_ctrl.sv
// key_search_ctrl: sequences a parallel key search across LANES engines and captures the first hit.
// Ports:
//    clk_i, rst_ni           clock, asynchronous active-low reset
//    start_i, abort_i        level search request, search termination
//    base_key_i, max_count_i lane-0 start key and last per-lane index, sampled when a search starts
//    lane_match_i            per-lane match flags, returned LAT cycles after the key was issued
//    lane_key_o, lane_valid_o candidate keys (lane i in bits [i*KEYW +: KEYW]) and their qualifier
//    count_o                 per-lane index of the next candidate to issue
//    key_out_o               found key in odd-parity 64-bit form
//    busy_o, found_o, exhausted_o  search status
module key_search_ctrl #(
   parameter int unsigned     LANES  = 16,
   parameter int unsigned     KEYW   = 56,
   parameter longint unsigned STRIDE = 64'd1 << (KEYW - $clog2(LANES)),
   parameter int unsigned     LAT    = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [KEYW-1:0]       base_key_i,
   input  logic [KEYW-1:0]       max_count_i,
   input  logic [LANES-1:0]      lane_match_i,
   output logic [LANES*KEYW-1:0] lane_key_o,
   output logic                  lane_valid_o,
   output logic [KEYW-1:0]       count_o,
   output logic [63:0]           key_out_o,
   output logic                  busy_o,
   output logic                  found_o,
   output logic                  exhausted_o
);
   localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
   localparam int DW = $clog2(LAT + 1);
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, FOUND, DONE} state_e;
   state_e state_q, state_d;
   logic [KEYW-1:0] count_q, count_d, base_q, base_d, max_q, max_d;
   logic [DW-1:0] drain_q, drain_d;
   logic [63:0] key_q, key_d;
   logic [KEYW-1:0] idx_q [LAT];
   logic vld_q [LAT];
   logic [LW-1:0] sel;
   logic hit;
   logic [KEYW-1:0] hit_key;
   // 56-bit key as eight 7-bit groups, MSB first, each padded with an odd-parity bit
   function automatic logic [63:0] expand(input logic [KEYW-1:0] k);
      logic [55:0] w;
      logic [63:0] r;
      w = 56'(k);
      r = '0;
      for (int g = 0; g < 8; g++) r[63-8*g -: 8] = {w[55-7*g -: 7], ~^w[55-7*g -: 7]};
      return r;
   endfunction
   always_comb begin
      sel = '0;
      for (int l = LANES - 1; l >= 0; l--) if (lane_match_i[l]) sel = LW'(l);
   end
   // only matches paired with a live issued index count, and only while searching
   assign hit = (state_q == RUN || state_q == DRAIN) && vld_q[LAT-1] && |lane_match_i;
   assign hit_key = base_q + KEYW'(64'(sel) * STRIDE) + idx_q[LAT-1];
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      base_d = base_q;
      max_d = max_q;
      drain_d = drain_q;
      key_d = key_q;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = RUN;
            base_d = base_key_i;
            max_d = max_count_i;
            count_d = '0;
         end
         RUN: if (abort_i) state_d = IDLE;
            else if (hit) begin
               state_d = FOUND;
               key_d = expand(hit_key);
            end else begin
               count_d = count_q + KEYW'(1);
               if (count_q == max_q) begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end
         DRAIN: if (abort_i) state_d = IDLE;
            else if (hit) begin
               state_d = FOUND;
               key_d = expand(hit_key);
            end else if (drain_q == DW'(LAT - 1)) state_d = DONE;
            else drain_d = drain_q + DW'(1);
         FOUND, DONE: if (!start_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) begin
         count_d = '0;
         key_d = '0;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         count_q <= '0;
         base_q <= '0;
         max_q <= '0;
         drain_q <= '0;
         key_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            idx_q[i] <= '0;
            vld_q[i] <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         base_q <= base_d;
         max_q <= max_d;
         drain_q <= drain_d;
         key_q <= key_d;
         // flushing on the way to IDLE keeps stale issues from matching in the next search
         idx_q[0] <= count_q;
         vld_q[0] <= state_d != IDLE && lane_valid_o;
         for (int i = 1; i < LAT; i++) begin
            idx_q[i] <= idx_q[i-1];
            vld_q[i] <= state_d != IDLE && vld_q[i-1];
         end
      end
   end
   assign lane_valid_o = state_q == RUN;
   assign busy_o = state_q == RUN || state_q == DRAIN;
   assign found_o = state_q == FOUND;
   assign exhausted_o = state_q == DONE;
   assign count_o = count_q;
   assign key_out_o = key_q;
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_key_o[g*KEYW +: KEYW] = lane_valid_o ? base_q + KEYW'(64'(g) * STRIDE) + count_q : '0;
   end
endmodule

// File: tb/tb_key_search_ctrl.sv
// tb_key_search_ctrl: directed self-checking bench for key_search_ctrl (LANES=4, KEYW=56, LAT=2).
module tb_key_search_ctrl;
   logic clk = 1'b0;
   logic rst_n, start, abort;
   logic [55:0] base_key, max_count;
   logic [3:0] lane_match;
   logic [223:0] lane_key;
   logic lane_valid, busy, found, exhausted;
   logic [55:0] count;
   logic [63:0] key_out;
   int errors = 0;
   int checks = 0;
   int v;
   key_search_ctrl #(.LANES(4), .KEYW(56), .LAT(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .base_key_i(base_key), .max_count_i(max_count), .lane_match_i(lane_match),
      .lane_key_o(lane_key), .lane_valid_o(lane_valid), .count_o(count),
      .key_out_o(key_out), .busy_o(busy), .found_o(found), .exhausted_o(exhausted)
   );
   always #5 clk = ~clk;
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      base_key = '0;
      max_count = '0;
      lane_match = '0;
      #1;
      chk("rst_valid", lane_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_found", found, 0);
      chk("rst_exh", exhausted, 0);
      chk("rst_count", count, 0);
      chk("rst_key", key_out, 0);
      tick(2);
      rst_n = 1'b1;
      tick();
      chk("idle_valid", lane_valid, 0);
      // single match on lane 2 for index 5
      base_key = 56'd0;
      max_count = 56'd15;
      start = 1'b1;
      tick();
      chk("t1_busy", busy, 1);
      chk("t1_valid", lane_valid, 1);
      chk("t1_count0", count, 0);
      chk("t1_lane1_key", lane_key[56 +: 56], 64'h0040_0000_0000_0000);
      tick(5);
      chk("t1_lane3_key", lane_key[168 +: 56], 64'h00C0_0000_0000_0005);
      tick(2);
      chk("t1_count7", count, 7);
      lane_match = 4'b0100;
      tick();
      lane_match = 4'b0000;
      chk("t1_found", found, 1);
      chk("t1_key", key_out, 64'h8001_0101_0101_010B);
      chk("t1_notbusy", busy, 0);
      chk("t1_novalid", lane_valid, 0);
      chk("t1_exh", exhausted, 0);
      chk("t1_count_frz", count, 7);
      lane_match = 4'b0001;
      tick(2);
      lane_match = 4'b0000;
      chk("t1_count_hold", count, 7);
      chk("t1_key_hold", key_out, 64'h8001_0101_0101_010B);
      chk("t1_found_hold", found, 1);
      start = 1'b0;
      tick();
      chk("t1_idle_found", found, 0);
      chk("t1_idle_key", key_out, 0);
      chk("t1_idle_count", count, 0);
      // no match: exhaust the range
      max_count = 56'd7;
      start = 1'b1;
      tick();
      v = 0;
      repeat (8) begin
         v += int'(lane_valid);
         tick();
      end
      chk("t2_valid_cycles", v, 8);
      chk("t2_drain_valid", lane_valid, 0);
      chk("t2_drain_busy", busy, 1);
      chk("t2_drain_count", count, 8);
      tick();
      chk("t2_drain2_busy", busy, 1);
      chk("t2_drain2_exh", exhausted, 0);
      tick();
      chk("t2_exh", exhausted, 1);
      chk("t2_found", found, 0);
      chk("t2_busy", busy, 0);
      chk("t2_count", count, 8);
      tick();
      chk("t2_exh_hold", exhausted, 1);
      start = 1'b0;
      tick();
      chk("t2_idle_exh", exhausted, 0);
      // two lanes match at once: lane 1 wins over lane 3
      max_count = 56'd15;
      start = 1'b1;
      tick();
      tick(5);
      lane_match = 4'b1010;
      tick();
      lane_match = 4'b0000;
      chk("t3_found", found, 1);
      chk("t3_key", key_out, 64'h4001_0101_0101_0107);
      start = 1'b0;
      tick();
      chk("t3_idle", found, 0);
      // match for the last index lands in DRAIN; start dropped mid-search is ignored
      max_count = 56'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(7);
      chk("t4_run_busy", busy, 1);
      chk("t4_run_count", count, 7);
      tick();
      chk("t4_drain_busy", busy, 1);
      chk("t4_drain_valid", lane_valid, 0);
      tick();
      lane_match = 4'b0001;
      tick();
      lane_match = 4'b0000;
      chk("t4_found", found, 1);
      chk("t4_exh", exhausted, 0);
      chk("t4_key", key_out, 64'h0101_0101_0101_010E);
      tick();
      chk("t4_idle", found, 0);
      // abort beats a same-cycle match
      max_count = 56'd15;
      start = 1'b1;
      tick();
      tick(3);
      lane_match = 4'b0001;
      abort = 1'b1;
      tick();
      lane_match = 4'b0000;
      abort = 1'b0;
      start = 1'b0;
      chk("t5_found", found, 0);
      chk("t5_valid", lane_valid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_count", count, 0);
      chk("t5_key", key_out, 0);
      tick();
      chk("t5_stay_idle", busy, 0);
      // asynchronous reset mid-run, then a fresh search
      base_key = 56'h123;
      start = 1'b1;
      tick();
      tick(4);
      chk("t6_count4", count, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", lane_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_found", found, 0);
      tick();
      chk("t6_rst_hold", busy, 0);
      rst_n = 1'b1;
      tick();
      chk("t6_restart_busy", busy, 1);
      chk("t6_restart_count", count, 0);
      chk("t6_lane0_key", lane_key[0 +: 56], 64'h123);
      tick();
      chk("t6_lane3_key", lane_key[168 +: 56], 64'h00C0_0000_0000_0124);
      abort = 1'b1;
      start = 1'b0;
      tick();
      abort = 1'b0;
      chk("t6_abort", busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
